td4_prog_mem: RTL and testbench
===============================

# td4_prog_mem

Program memory and serial loader for the TD4 CPU core: the instruction-supplying end of the CPU's `opcode`/`immediate` fetch interface. It holds 16 eight-bit instruction words, filled bit-serially from an external loader pin. It presents the word addressed by the CPU's `pc` as `{opcode, immediate}`, and holds the CPU in reset via `cpu_run` until a full program has been loaded.

## Interface
- `DEPTH`, 16: instruction words; the address width is 4 bits and matches the CPU `pc`.
- `WORD_W`, 8: bits per instruction word. `[7:4]` is the opcode and `[3:0]` is the immediate.
- `clk`  input  1  the single clock for the block.
- `rst`  input  1  reset: synchronous, active-high. Clears the FSM, all counters, all flags and all memory.
- `load_start`  input  1  single-cycle pulse that begins or restarts a program load at word 0.
- `load_bit_valid`  input  1  qualifies `load_bit` for this cycle.
- `load_bit`  input  1  serial program data, MSB first per word.
- `pc`  input  4  fetch address from the CPU.
- `opcode`  output  4  instruction bits `[7:4]` at `pc`.
- `immediate`  output  4  instruction bits `[3:0]` at `pc`.
- `cpu_run`  output  1  1 only in RUN; drives the CPU's active-low reset.
- `load_done`  output  1  one-cycle pulse when word 15 is committed.
- `load_err`  output  1  sticky parity error flag. It exists only with the macro; otherwise it is tied 0.

## Operation
- The FSM has three states: IDLE, LOAD and RUN. Reset puts it in IDLE.
- Transitions:
  - IDLE→LOAD on `load_start`.
  - LOAD→RUN on the commit of word 15.
  - RUN→LOAD on `load_start`, which reloads the program.
  - LOAD→LOAD on `load_start`, which restarts at word 0 and clears the bit count.
- Entering LOAD clears `load_err`.
- Data path in LOAD:
  - Each cycle with `load_bit_valid`=1, the shift register takes `{sr[6:0], load_bit}`.
  - The bit counter counts to `WORD_W` (or `WORD_W`+1 with parity).
  - When the counter completes, the word is written to `mem[waddr]`, `waddr` increments, and the bit counter clears.
- A `load_start` in the same cycle as a valid bit takes priority; the bit is discarded.
- `load_bit_valid` is ignored outside LOAD.
- Fetch outputs:
  - In RUN, `{opcode, immediate}` = `mem[pc]`, combinational from `pc`.
  - In IDLE and LOAD, the outputs are forced to 8'h00.
- Memory written by a partial load is kept, but `cpu_run` stays 0 until a full 16-word load completes.
- `waddr` wraps 15→0 at the commit of word 15. No further writes occur until the next `load_start`.

## Timing
- Reset values: `opcode`=0, `immediate`=0, `cpu_run`=0, `load_done`=0, `load_err`=0, all mem words = 8'h00.
- Reset asserted mid-load goes to IDLE the next edge and discards the partial word.
- Word commit happens on the clock edge that samples the last bit of the word. The written data is visible to fetch from the next cycle.
- For word 15, on the commit edge:
  - `load_done` rises for exactly 1 cycle.
  - The state becomes RUN.
  - `cpu_run` rises.
- A minimum full load takes 128 valid-bit cycles (144 with parity).
- `cpu_run` falls on the edge that samples `load_start` in RUN.
- Fetch latency is 0 cycles (combinational). The CPU samples the instruction on its own clock edge.

## Configuration
- `TD4_PROG_MEM_PARITY_EN` defined:
  - Each word is 9 serial bits: 8 data bits, MSB first, then 1 parity bit. Odd parity is taken over all 9 bits.
  - On a mismatch, the word is not written, `load_err` is set (sticky), and the FSM returns to IDLE.
- `TD4_PROG_MEM_PARITY_EN` undefined: words are 8 bits and `load_err` is constant 0.

## Structure
- Shared package `td4_pkg`:
  - FSM state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2).
  - `TD4_DEPTH`=16 and `TD4_WORD_W`=8.
  - `TD4_NOP`=8'h00.
- Sub-module `td4_serial_deser`:
  - Contains the shift register, the bit counter and the optional parity check.
  - Outputs: `word_valid` pulse, `word` [7:0], and `parity_bad`.
  - The top level owns the FSM, `waddr` and the memory.

## Test plan
- Reset then idle 10 cycles: expect `cpu_run`=0 and `opcode`/`immediate`=0 for any `pc`; `load_bit_valid` pulses have no effect.
- `load_start`, then 128 bits where word n = {4'hC, n}: expect `load_done` 1 cycle after the final bit and `cpu_run`=1. `pc`=5 gives `opcode`=4'hC, `immediate`=4'h5.
- Valid bits gapped every other cycle: expect the same result as a contiguous load, with commit on the 128th valid bit.
- Mid-load (after word 6), pulse `load_start`, then 128 bits of 8'hA3: expect all words = 8'hA3 and `cpu_run`=1 only after the second load.
- In RUN, pulse `load_start`: expect `cpu_run`=0 and outputs 0 the next cycle. Assert `rst` at bit 40: expect IDLE and all memory = 0.
- With the macro, corrupt the parity of word 3: expect `load_err`=1, state IDLE, `cpu_run`=0, word 3 unchanged. A subsequent `load_start` clears `load_err`.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared TD4 definitions: memory geometry, the NOP word and the program-memory FSM encoding.
package td4_pkg;
  localparam int TD4_DEPTH  = 16;
  localparam int TD4_WORD_W = 8;
  localparam int TD4_AW     = $clog2(TD4_DEPTH);

  localparam logic [TD4_WORD_W-1:0] TD4_NOP = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } td4_state_e;
endpackage

// File: rtl/td4_prog_mem_if.sv
// Loader + fetch bus between the CPU/loader side (master) and td4_prog_mem (slave).
interface td4_prog_mem_if;
  import td4_pkg::*;

  logic              load_start;
  logic              load_bit_valid;
  logic              load_bit;
  logic [TD4_AW-1:0] pc;
  logic [3:0]        opcode;
  logic [3:0]        immediate;
  logic              cpu_run;
  logic              load_done;
  logic              load_err;

  modport master (
    output load_start, load_bit_valid, load_bit, pc,
    input  opcode, immediate, cpu_run, load_done, load_err
  );

  modport slave (
    input  load_start, load_bit_valid, load_bit, pc,
    output opcode, immediate, cpu_run, load_done, load_err
  );
endinterface

// File: rtl/td4_serial_deser.sv
// MSB-first bit deserialiser for program words; with TD4_PROG_MEM_PARITY_EN each word
// carries a trailing odd-parity bit that is checked on the final bit.
module td4_serial_deser
  import td4_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_bit_valid,
  input  logic                  i_bit,
  output logic                  o_word_valid,
  output logic [TD4_WORD_W-1:0] o_word,
  output logic                  o_parity_bad
);
`ifdef TD4_PROG_MEM_PARITY_EN
  localparam int BITS = TD4_WORD_W + 1;
`else
  localparam int BITS = TD4_WORD_W;
`endif
  // The final bit of a word is used live on its commit edge, so it is never stored.
  localparam int          SR_W     = BITS - 1;
  localparam logic [3:0]  LAST_CNT = 4'(BITS - 1);

  logic [SR_W-1:0] r_sr;
  logic [3:0]      r_cnt;
  logic            w_last;

  assign w_last       = (r_cnt == LAST_CNT);
  assign o_word_valid = i_bit_valid & w_last;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (i_bit_valid) begin
      r_sr  <= {r_sr[SR_W-2:0], i_bit};
      r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
    end
  end

`ifdef TD4_PROG_MEM_PARITY_EN
  assign o_word       = r_sr;
  assign o_parity_bad = ~(^{r_sr, i_bit});
`else
  assign o_word       = {r_sr, i_bit};
  assign o_parity_bad = 1'b0;
`endif
endmodule

// File: rtl/td4_prog_mem.sv
// TD4 program memory: 16x8 store filled by a serial loader, fetched combinationally in RUN.
// Optional parity checking and the sticky load_err flag are enabled by TD4_PROG_MEM_PARITY_EN.
module td4_prog_mem
  import td4_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  td4_prog_mem_if.slave  bus
);
  td4_state_e            r_state;
  td4_state_e            w_state_next;
  logic [TD4_AW-1:0]     r_waddr;
  logic [TD4_WORD_W-1:0] r_mem [TD4_DEPTH];
  logic                  r_load_done;

  logic                  w_in_load;
  logic                  w_bit_valid;
  logic                  w_clear;
  logic                  w_word_valid;
  logic [TD4_WORD_W-1:0] w_word;
  logic                  w_parity_bad;
  logic                  w_we;
  logic                  w_done;

  // A load_start wins over a coincident valid bit, which is dropped.
  assign w_in_load   = (r_state == ST_LOAD);
  assign w_bit_valid = bus.load_bit_valid & w_in_load & ~bus.load_start;
  assign w_clear     = bus.load_start | ~w_in_load;

  td4_serial_deser u_deser (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_bit_valid  (w_bit_valid),
    .i_bit        (bus.load_bit),
    .o_word_valid (w_word_valid),
    .o_word       (w_word),
    .o_parity_bad (w_parity_bad)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_we         = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      ST_IDLE: if (bus.load_start) w_state_next = ST_LOAD;
      ST_LOAD: begin
        if (bus.load_start) begin
          w_state_next = ST_LOAD;
        end else if (w_word_valid) begin
          if (w_parity_bad) begin
            w_state_next = ST_IDLE;
          end else begin
            w_we = 1'b1;
            if (r_waddr == TD4_AW'(TD4_DEPTH - 1)) begin
              w_state_next = ST_RUN;
              w_done       = 1'b1;
            end
          end
        end
      end
      ST_RUN:  if (bus.load_start) w_state_next = ST_LOAD;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_waddr     <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_load_done <= w_done;
      if (bus.load_start) r_waddr <= '0;
      else if (w_we)      r_waddr <= r_waddr + 1'b1;
    end
  end

  // NOTE: the store is reset word by word because a reset must leave NOPs behind for the CPU.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TD4_DEPTH; i++) r_mem[i] <= TD4_NOP;
    end else if (w_we) begin
      r_mem[r_waddr] <= w_word;
    end
  end

`ifdef TD4_PROG_MEM_PARITY_EN
  logic r_load_err;

  always_ff @(posedge clk) begin
    if (rst || bus.load_start)                                r_load_err <= 1'b0;
    else if (w_in_load && w_word_valid && w_parity_bad)        r_load_err <= 1'b1;
  end

  assign bus.load_err = r_load_err;
`else
  assign bus.load_err = 1'b0;
`endif

  assign {bus.opcode, bus.immediate} = (r_state == ST_RUN) ? r_mem[bus.pc] : TD4_NOP;
  assign bus.cpu_run   = (r_state == ST_RUN);
  assign bus.load_done = r_load_done;
endmodule

// File: tb/tb_td4_prog_mem.sv
// Self-checking bench for td4_prog_mem: loaded words are queued as expected fetch data
// and compared when the memory is swept in RUN.
module tb_td4_prog_mem;
  import td4_pkg::*;

`ifdef TD4_PROG_MEM_PARITY_EN
  localparam int BPW = 9;
`else
  localparam int BPW = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  td4_prog_mem_if bus ();

  td4_prog_mem dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input int gap, input bit bad_par);
    logic [8:0] bits;
    bits = {w, (~^w) ^ bad_par};
    for (int i = 0; i < BPW; i++) begin
      for (int g = 0; g < gap; g++) tick();
      bus.load_bit_valid = 1'b1;
      bus.load_bit       = bits[8-i];
      tick();
      bus.load_bit_valid = 1'b0;
    end
  endtask

  // Pulses load_start (optionally with a coincident valid bit) and loads 16 words.
  task automatic load_program(input string tag, input bit use_fixed, input logic [7:0] fixed,
                              input int gap, input bit bit_on_start);
    logic [7:0] w;
    bus.load_start     = 1'b1;
    bus.load_bit_valid = bit_on_start;
    bus.load_bit       = 1'b1;
    tick();
    bus.load_start     = 1'b0;
    bus.load_bit_valid = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 16; n++) begin
      w = use_fixed ? fixed : {4'hC, 4'(n)};
      send_word(w, gap, 1'b0);
      exp_q.push_back(w);
      if (n == 14) begin
        n_vec++;
        if (bus.cpu_run !== 1'b0 || bus.load_done !== 1'b0) begin
          n_err++;
          $display("FAIL %s_early_run: cpu_run=%b load_done=%b want 0 0", tag, bus.cpu_run, bus.load_done);
        end
      end
    end
    n_vec++;
    if (bus.load_done !== 1'b1 || bus.cpu_run !== 1'b1) begin
      n_err++;
      $display("FAIL %s_commit15: load_done=%b cpu_run=%b want 1 1", tag, bus.load_done, bus.cpu_run);
    end
    tick();
    n_vec++;
    if (bus.load_done !== 1'b0 || bus.cpu_run !== 1'b1) begin
      n_err++;
      $display("FAIL %s_done_pulse: load_done=%b cpu_run=%b want 0 1", tag, bus.load_done, bus.cpu_run);
    end
  endtask

  task automatic check_fetch(input string tag);
    logic [7:0] exp;
    for (int p = 0; p < 16; p++) begin
      bus.pc = 4'(p);
      #1;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL %s_queue_empty: pc=%0d has no expected word", tag, p);
      end else begin
        exp = exp_q.pop_front();
        if ({bus.opcode, bus.immediate} !== exp) begin
          n_err++;
          $display("FAIL %s_fetch: pc=%0d got %h want %h", tag, p, {bus.opcode, bus.immediate}, exp);
        end
      end
    end
  endtask

  task automatic check_mem_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (dut.r_mem[i] !== 8'h00) begin
        n_err++;
        $display("FAIL %s_mem: word %0d got %h want 00", tag, i, dut.r_mem[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.load_bit_valid = c[0];
      bus.load_bit       = 1'b1;
      tick();
    end
    bus.load_bit_valid = 1'b0;
    n_vec++;
    if (bus.cpu_run !== 1'b0 || bus.load_done !== 1'b0 || bus.load_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: cpu_run=%b load_done=%b load_err=%b want 0 0 0",
               bus.cpu_run, bus.load_done, bus.load_err);
    end
    for (int p = 0; p < 16; p++) begin
      bus.pc = 4'(p);
      #1;
      n_vec++;
      if (bus.opcode !== 4'h0 || bus.immediate !== 4'h0) begin
        n_err++;
        $display("FAIL reset_fetch: pc=%0d got %h%h want 00", p, bus.opcode, bus.immediate);
      end
    end
    check_mem_zero("reset");
  endtask

  task automatic test_full_load();
    load_program("full", 1'b0, 8'h00, 0, 1'b0);
    bus.pc = 4'd5;
    #1;
    n_vec++;
    if (bus.opcode !== 4'hC || bus.immediate !== 4'h5) begin
      n_err++;
      $display("FAIL full_pc5: got %h/%h want c/5", bus.opcode, bus.immediate);
    end
    check_fetch("full");
  endtask

  task automatic test_gapped_load();
    load_program("gapped", 1'b0, 8'h00, 1, 1'b0);
    check_fetch("gapped");
  endtask

  task automatic test_restart();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int n = 0; n < 7; n++) send_word({4'hC, 4'(n)}, 0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      bus.load_bit_valid = 1'b1;
      bus.load_bit       = 1'b0;
      tick();
    end
    bus.load_bit_valid = 1'b0;
    n_vec++;
    if (bus.cpu_run !== 1'b0) begin
      n_err++;
      $display("FAIL restart_partial_run: cpu_run=%b want 0", bus.cpu_run);
    end
    load_program("restart", 1'b1, 8'hA3, 0, 1'b1);
    check_fetch("restart");
  endtask

`ifdef TD4_PROG_MEM_PARITY_EN
  task automatic test_parity();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int n = 0; n < 3; n++) send_word(8'h50 + 8'(n), 0, 1'b0);
    send_word(8'h53, 0, 1'b1);
    n_vec++;
    if (bus.load_err !== 1'b1 || bus.cpu_run !== 1'b0 || dut.r_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL parity_err: load_err=%b cpu_run=%b state=%0d want 1 0 0",
               bus.load_err, bus.cpu_run, dut.r_state);
    end
    n_vec++;
    if (dut.r_mem[3] !== 8'hA3 || dut.r_mem[2] !== 8'h52) begin
      n_err++;
      $display("FAIL parity_mem: w3=%h w2=%h want a3 52", dut.r_mem[3], dut.r_mem[2]);
    end
    send_word(8'h54, 0, 1'b0);
    n_vec++;
    if (dut.r_mem[3] !== 8'hA3 || bus.load_err !== 1'b1) begin
      n_err++;
      $display("FAIL parity_idle: w3=%h load_err=%b want a3 1", dut.r_mem[3], bus.load_err);
    end
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    n_vec++;
    if (bus.load_err !== 1'b0) begin
      n_err++;
      $display("FAIL parity_clear: load_err=%b want 0", bus.load_err);
    end
  endtask
`endif

  task automatic test_reload_and_reset();
    load_program("reload", 1'b0, 8'h00, 0, 1'b0);
    check_fetch("reload");
    bus.load_start = 1'b1;
    bus.pc         = 4'd5;
    tick();
    bus.load_start = 1'b0;
    n_vec++;
    if (bus.cpu_run !== 1'b0 || bus.opcode !== 4'h0 || bus.immediate !== 4'h0) begin
      n_err++;
      $display("FAIL reload_run_drop: cpu_run=%b fetch=%h%h want 0 00",
               bus.cpu_run, bus.opcode, bus.immediate);
    end
    for (int b = 0; b < 40; b++) begin
      bus.load_bit_valid = 1'b1;
      bus.load_bit       = 1'b1;
      if (b == 39) rst = 1'b1;
      tick();
    end
    rst                = 1'b0;
    bus.load_bit_valid = 1'b0;
    n_vec++;
    if (bus.cpu_run !== 1'b0 || bus.load_done !== 1'b0 || dut.r_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL midload_reset: cpu_run=%b load_done=%b state=%0d want 0 0 0",
               bus.cpu_run, bus.load_done, dut.r_state);
    end
    check_mem_zero("midload_reset");
  endtask

  initial begin
    rst                = 1'b1;
    bus.load_start     = 1'b0;
    bus.load_bit_valid = 1'b0;
    bus.load_bit       = 1'b0;
    bus.pc             = 4'd0;
    test_reset();
    test_full_load();
    test_gapped_load();
    test_restart();
`ifdef TD4_PROG_MEM_PARITY_EN
    test_parity();
`endif
    test_reload_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
